// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: debounced step/run scheduler that issues a one-cycle clock-enable to the core.
// Define SM_CLK_CTRL_BURST_EN to add burstLen: each press then issues burstLen+1 tick-spaced pulses.
module sm_clk_ctrl #(
   parameter int DB_W  = 20,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stepBtn_n,
   input  logic             run,
   input  logic [3:0]       devide,
`ifdef SM_CLK_CTRL_BURST_EN
   input  logic [3:0]       burstLen,
`endif
   output logic             cpuEn,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stepCnt,
   output logic             ledTick
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HOLD = 2'd3
   } state_e;

   logic             btnMeta_q, btnSync_q;
   logic             runMeta_q, runSync_q;
   logic             btnStable_q, btnStableDly_q;
   logic [DB_W-1:0]  dbCnt_q;
   logic             btnPress;

   state_e           state_q, state_d;
   logic [14:0]      divCnt_q, divCnt_d, mask;
   logic             tickNext;
   logic             cpuEn_q, cpuEn_d;
   logic [CNT_W-1:0] stepCnt_q;
   logic             ledTick_q;
`ifdef SM_CLK_CTRL_BURST_EN
   logic [3:0]       burstCnt_q, burstCnt_d;
   logic             stepEntry, burstPulse;
`endif

   // Button idles released (1) so a button held through reset must debounce as a fresh press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btnMeta_q      <= 1'b1;
         btnSync_q      <= 1'b1;
         runMeta_q      <= 1'b0;
         runSync_q      <= 1'b0;
         btnStable_q    <= 1'b1;
         btnStableDly_q <= 1'b1;
         dbCnt_q        <= '0;
      end else begin
         btnMeta_q      <= stepBtn_n;
         btnSync_q      <= btnMeta_q;
         runMeta_q      <= run;
         runSync_q      <= runMeta_q;
         btnStableDly_q <= btnStable_q;
         if (btnSync_q == btnStable_q) begin
            dbCnt_q <= '0;
         end else if (&dbCnt_q) begin
            btnStable_q <= btnSync_q;
            dbCnt_q     <= '0;
         end else begin
            dbCnt_q <= dbCnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      btnPress = btnStableDly_q & ~btnStable_q;
      mask     = (15'd1 << devide) - 15'd1;
      state_d  = state_q;
      case (state_q)
         IDLE: begin
            if (runSync_q)     state_d = RUN;
            else if (btnPress) state_d = STEP;
         end
         RUN: begin
            if (!runSync_q) state_d = IDLE;
         end
         STEP: begin
`ifdef SM_CLK_CTRL_BURST_EN
            if (runSync_q || burstCnt_q == 4'd0) state_d = btnStable_q ? IDLE : HOLD;
`else
            state_d = btnStable_q ? IDLE : HOLD;
`endif
         end
         HOLD: begin
            if (btnStable_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // In burst mode the entry pulse counts as a tick, so the divider is preloaded to all-ones.
      if (state_q != RUN && state_d == RUN) begin
         divCnt_d = '0;
`ifdef SM_CLK_CTRL_BURST_EN
      end else if (state_q != STEP && state_d == STEP) begin
         divCnt_d = '1;
`endif
      end else begin
         divCnt_d = divCnt_q + 15'd1;
      end
      tickNext = (divCnt_d & mask) == mask;

`ifdef SM_CLK_CTRL_BURST_EN
      stepEntry  = (state_q != STEP) && (state_d == STEP);
      burstPulse = (state_q == STEP) && (state_d == STEP) && tickNext;
      cpuEn_d    = stepEntry | burstPulse | ((state_q == RUN) & runSync_q & tickNext);
      if (stepEntry)       burstCnt_d = burstLen;
      else if (burstPulse) burstCnt_d = burstCnt_q - 4'd1;
      else                 burstCnt_d = burstCnt_q;
`else
      cpuEn_d = (state_d == STEP) | ((state_q == RUN) & runSync_q & tickNext);
`endif
   end

   // Counter and heartbeat update together with the enable so they always include the current pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         divCnt_q   <= '0;
         cpuEn_q    <= 1'b0;
         stepCnt_q  <= '0;
         ledTick_q  <= 1'b0;
`ifdef SM_CLK_CTRL_BURST_EN
         burstCnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         divCnt_q   <= divCnt_d;
         cpuEn_q    <= cpuEn_d;
         stepCnt_q  <= stepCnt_q + {{(CNT_W-1){1'b0}}, cpuEn_d};
         ledTick_q  <= ledTick_q ^ cpuEn_d;
`ifdef SM_CLK_CTRL_BURST_EN
         burstCnt_q <= burstCnt_d;
`endif
      end
   end

   assign cpuEn   = cpuEn_q;
   assign state   = state_q;
   assign stepCnt = stepCnt_q;
   assign ledTick = ledTick_q;

endmodule
